cpu_mem_resp: RTL and testbench

CPU_MEM_RESP -- requirements
Module: cpu_mem_resp

---
 rtl/cpu_mem_resp_if.sv | 22 ++
 rtl/cpu_mem_resp.sv | 149 ++++++++++++++
 tb/tb_cpu_mem_resp.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_resp_if.sv
// CPU-side memory access bus between a requesting CPU and cpu_mem_resp.
// Signals:
//   req   - access request, held high by the CPU until ack
//   we    - 1 = write, 0 = read (qualified by req)
//   addr  - byte address (qualified by req)
//   wdata - write data (qualified by req and we)
//   ack   - one-cycle completion pulse from the responder
//   rdata - read data, valid in the ack cycle and held until the next ack
interface cpu_mem_resp_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/cpu_mem_resp.sv
// Memory responder for a simple CPU bus: internal RAM at addresses
// 0..2^ADDR_W-2 and an output-port register at the all-ones address.
// Optional feature macro: CPU_MEM_WAIT_EN inserts WAIT_CYCLES wait states
// (with abort on req drop) before ack; when undefined, ack follows accept
// by one cycle and WAIT_CYCLES is unused.
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous active-high reset
//   bus      - cpu_mem_resp_if slave (req/we/addr/wdata in, ack/rdata out)
//   port_out - output-port register
module cpu_mem_resp #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    cpu_mem_resp_if.slave     bus,
    output logic [DATA_W-1:0] port_out
);
    localparam int unsigned RAM_DEPTH = (1 << ADDR_W) - 1;
    localparam logic [ADDR_W-1:0] PORT_ADDR = '1;

    // Elaboration-time range check on the wait-state count.
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("cpu_mem_resp: WAIT_CYCLES out of range 1..15");
    end

`ifdef CPU_MEM_WAIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;
    localparam int unsigned CNT_W = 4;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd2} state_t;
`endif

    state_t            state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic              capture_c;
    logic              load_c;
    logic              acc_we_c;
    logic [ADDR_W-1:0] acc_addr_c;
    logic [DATA_W-1:0] rd_c;
    logic              commit_c;
    logic [DATA_W-1:0] mem [RAM_DEPTH];

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;

    // Next-state logic; load_c marks the transition into ACK.
    always_comb begin
        state_d   = state_q;
        capture_c = 1'b0;
        load_c    = 1'b0;
`ifdef CPU_MEM_WAIT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    capture_c = 1'b1;
`ifdef CPU_MEM_WAIT_EN
                    state_d   = WAIT;
                    cnt_d     = '0;
`else
                    state_d   = ACK;
                    load_c    = 1'b1;
`endif
                end
            end
`ifdef CPU_MEM_WAIT_EN
            WAIT: begin
                if (!bus.req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
                    state_d = ACK;
                    load_c  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Without wait states the read happens on the accept edge, so the live
    // bus fields are used; otherwise the captured copies.
    always_comb begin
`ifdef CPU_MEM_WAIT_EN
        acc_we_c   = we_q;
        acc_addr_c = addr_q;
`else
        acc_we_c   = bus.we;
        acc_addr_c = bus.addr;
`endif
        rd_c = (acc_addr_c == PORT_ADDR) ? port_out : mem[acc_addr_c];
    end

    // Writes commit at the end of the ACK cycle from the captured fields.
    assign commit_c = (state_q == ACK) && we_q;

    // State, capture and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            port_out <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef CPU_MEM_WAIT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= load_c;
`ifdef CPU_MEM_WAIT_EN
            cnt_q   <= cnt_d;
`endif
            if (capture_c) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (load_c && !acc_we_c) begin
                rdata_q <= rd_c;
            end
            if (commit_c && addr_q == PORT_ADDR) begin
                port_out <= wdata_q;
            end
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && commit_c && addr_q != PORT_ADDR) begin
            mem[addr_q] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_cpu_mem_resp.sv
module tb_cpu_mem_resp;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned WC = 2;
`ifdef CPU_MEM_WAIT_EN
    localparam int LAT = WC + 1;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [DW-1:0] rd;
        string         name;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] port_out;
    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;

    cpu_mem_resp_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cpu_mem_resp #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .port_out (port_out)
    );

    always #5 clk = ~clk;

    // Monitor: every ack pops one expected rdata.
    always @(negedge clk) begin
        if (!reset && bus.ack === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: ack=1 rdata=%h required no ack", bus.rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.rdata !== e.rd) begin
                    errors++;
                    $display("FAIL %s rdata: got %h required %h", e.name, bus.rdata, e.rd);
                end
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req_v);
        end
    endtask

    // One access; latency measured in cycles from request (or previous ack).
    task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp_rd, input int exp_lat, input bit keep,
                          input string name);
        int   n;
        bit   got;
        exp_t e;
        if (bus.req !== 1'b1) begin
            @(posedge clk); #1;
        end
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        e.rd   = exp_rd;
        e.name = name;
        exp_q.push_back(e);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.ack === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || n != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (ack seen=%0b) required %0d", name, n, got, exp_lat);
        end
        if (!got) void'(exp_q.pop_back());
        if (!keep) begin
            // Scramble the bus while ACK is in progress; the captured copy must be used.
            bus.req   = 1'b0;
            bus.we    = ~w;
            bus.addr  = ~a;
            bus.wdata = ~d;
            @(posedge clk); #1;
            check({name, " ack_one_cycle"}, DW'(bus.ack), 8'h00);
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", DW'(bus.ack), 8'h00);
        check("reset_rdata", bus.rdata, 8'h00);
        check("reset_port_out", port_out, 8'h00);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_ack", DW'(bus.ack), 8'h00);

        access(1'b1, 8'h10, 8'hA5, 8'h00, LAT, 1'b0, "wr_10");
        access(1'b0, 8'h10, 8'h00, 8'hA5, LAT, 1'b0, "rd_10");
        access(1'b1, 8'h20, 8'h11, 8'hA5, LAT, 1'b0, "wr_20");
        access(1'b0, 8'h20, 8'h00, 8'h11, LAT, 1'b0, "rd_20");
        access(1'b1, 8'h11, 8'h42, 8'h11, LAT, 1'b0, "wr_11");
        access(1'b1, 8'hFE, 8'hE7, 8'h11, LAT, 1'b0, "wr_FE");
        access(1'b0, 8'hFE, 8'h00, 8'hE7, LAT, 1'b0, "rd_FE");
        check("ram_no_port_alias", port_out, 8'h00);
        access(1'b1, 8'hFF, 8'h3C, 8'hE7, LAT, 1'b0, "wr_FF_3C");
        check("port_out_3C", port_out, 8'h3C);
        access(1'b0, 8'hFF, 8'h00, 8'h3C, LAT, 1'b0, "rd_FF");
        access(1'b1, 8'hFF, 8'h55, 8'h3C, LAT, 1'b0, "wr_FF_55");
        check("port_out_55", port_out, 8'h55);

        // Reset lands on an in-flight write of 0x99 to the port.
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 8'hFF;
        bus.wdata = 8'h99;
`ifdef CPU_MEM_WAIT_EN
        @(posedge clk); #1;
`endif
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        bus.req = 1'b0;
        check("rst_port_out", port_out, 8'h00);
        check("rst_ack", DW'(bus.ack), 8'h00);
        check("rst_rdata", bus.rdata, 8'h00);
        @(posedge clk); #1;
        check("rst_ack_after", DW'(bus.ack), 8'h00);
        check("rst_port_out_after", port_out, 8'h00);
        access(1'b0, 8'h10, 8'h00, 8'hA5, LAT, 1'b0, "rd_10_after_rst");
        access(1'b0, 8'hFF, 8'h00, 8'h00, LAT, 1'b0, "rd_FF_after_rst");

`ifdef CPU_MEM_WAIT_EN
        // Abort: req dropped after one WAIT cycle; no ack, no write.
        begin
            int acks;
            @(posedge clk); #1;
            bus.req   = 1'b1;
            bus.we    = 1'b1;
            bus.addr  = 8'h20;
            bus.wdata = 8'h77;
            @(posedge clk); #1;
            bus.req = 1'b0;
            acks = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (bus.ack === 1'b1) acks++;
            end
            check("abort_no_ack", DW'(acks), 8'h00);
        end
        access(1'b0, 8'h20, 8'h00, 8'h11, LAT, 1'b0, "rd_20_after_abort");
`endif

        // Back-to-back reads with req held high.
        access(1'b0, 8'h10, 8'h00, 8'hA5, LAT, 1'b1, "b2b_rd_10");
        access(1'b0, 8'h11, 8'h00, 8'h42, LAT + 1, 1'b0, "b2b_rd_11");

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", DW'(exp_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
